// File: rtl/kpyd_pkg.sv
// Shared types and sizing helpers for the keypad scanner.
// State encoding plus key-code and counter width functions.
package kpyd_pkg;

  typedef enum logic [1:0] {
    SETTLE,
    SAMPLE,
    EVAL,
    EMIT
  } kpyd_scan_state_e;

  function automatic int kpyd_code_w(input int rows, input int cols);
    return (rows * cols > 1) ? $clog2(rows * cols) : 1;
  endfunction

  function automatic int kpyd_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kpyd_prio_enc.sv
// Lowest-set-bit priority encoder.
// index is 0 when no bit is set; any flags a non-empty input.
module kpyd_prio_enc #(
  parameter int width_p = 16,
  parameter int idx_w_p = 4
) (
  input  logic [width_p-1:0] bits,
  output logic [idx_w_p-1:0] index,
  output logic               any
);

  // scan downward so the lowest set bit wins
  always_comb begin
    index = '0;
    any   = |bits;
    for (int i = width_p - 1; i >= 0; i--) begin
      if (bits[i]) index = idx_w_p'(i);
    end
  end

endmodule

// File: rtl/kpyd_scanner.sv
// Matrix keypad scanner with whole-matrix snapshot debounce.
// Define KPYD_SCAN_RELEASE_EN to also emit key release events.
module kpyd_scanner
  import kpyd_pkg::*;
#(
  parameter int cols_p          = 4,
  parameter int rows_p          = 4,
  parameter int settle_cycles_p = 16,
  parameter int stable_scans_p  = 4,
  localparam int code_w_lp = kpyd_code_w(rows_p, cols_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  output logic [cols_p-1:0]    col_o,
  input  logic [rows_p-1:0]    row_i,
  output logic                 key_valid_o,
  input  logic                 key_ready_i,
  output logic [code_w_lp-1:0] key_code_o,
  output logic                 key_release_o
);

  localparam int keys_lp  = rows_p * cols_p;
  localparam int col_w_lp = kpyd_cnt_w(cols_p);
  localparam int set_w_lp = kpyd_cnt_w(settle_cycles_p);
  localparam int mat_w_lp = kpyd_cnt_w(stable_scans_p);

  localparam logic [col_w_lp-1:0] col_last_lp =
    col_w_lp'(cols_p - 1);
  localparam logic [set_w_lp-1:0] set_last_lp =
    set_w_lp'(settle_cycles_p - 1);
  localparam logic [mat_w_lp-1:0] mat_top_lp =
    mat_w_lp'(stable_scans_p - 1);
  localparam logic [cols_p-1:0]   one_col_lp = 1;
  localparam logic [keys_lp-1:0]  one_key_lp = 1;

  kpyd_scan_state_e      state;
  logic [col_w_lp-1:0]   col_idx;
  logic [set_w_lp-1:0]   set_cnt;
  logic [mat_w_lp-1:0]   match;
  logic [keys_lp-1:0]    snap;
  logic [keys_lp-1:0]    prev;
  logic [keys_lp-1:0]    deb;
  logic [keys_lp-1:0]    pend;

  logic                  commit;
  logic                  xfer;
  logic [mat_w_lp-1:0]   match_nxt;
  logic [keys_lp-1:0]    diff;
  logic [keys_lp-1:0]    report;
  logic [keys_lp-1:0]    deb_nxt;
  logic [keys_lp-1:0]    done_bit;
  logic [keys_lp-1:0]    mask_nxt;
  logic [code_w_lp-1:0]  enc_idx;
  logic                  enc_any;

  // debounce decision and next pending-event mask
  always_comb begin
    match_nxt = '0;
    if (snap == prev) begin
      match_nxt = (match == mat_top_lp) ? match : match + 1'b1;
    end
    commit  = (state == EVAL) &&
              (match_nxt == mat_top_lp) &&
              (snap != deb);
    diff    = commit ? (snap ^ deb) : '0;
    deb_nxt = commit ? snap : deb;
`ifdef KPYD_SCAN_RELEASE_EN
    report  = diff;
`else
    report  = diff & snap;
`endif
    xfer     = (state == EMIT) && key_valid_o && key_ready_i;
    done_bit = one_key_lp << key_code_o;
    mask_nxt = pend;
    if (state == EVAL) begin
      mask_nxt = report;
    end else if (xfer) begin
      mask_nxt = pend & ~done_bit;
    end
  end

  kpyd_prio_enc #(
    .width_p(keys_lp),
    .idx_w_p(code_w_lp)
  ) u_enc (
    .bits (mask_nxt),
    .index(enc_idx),
    .any  (enc_any)
  );

  // scan sequencer, snapshot debounce and event handshake
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state       <= SETTLE;
      col_idx     <= '0;
      set_cnt     <= '0;
      match       <= '0;
      snap        <= '0;
      prev        <= '0;
      deb         <= '0;
      pend        <= '0;
      col_o       <= '1;
      key_valid_o <= 1'b0;
      key_code_o  <= '0;
`ifdef KPYD_SCAN_RELEASE_EN
      key_release_o <= 1'b0;
`endif
    end else begin
      unique case (state)
        SETTLE: begin
          col_o <= ~(one_col_lp << col_idx);
          if (set_cnt == set_last_lp) begin
            set_cnt <= '0;
            state   <= SAMPLE;
          end else begin
            set_cnt <= set_cnt + 1'b1;
          end
        end
        SAMPLE: begin
          col_o <= ~(one_col_lp << col_idx);
          snap[int'(col_idx)*rows_p +: rows_p] <= ~row_i;
          if (col_idx == col_last_lp) begin
            col_idx <= '0;
            state   <= EVAL;
          end else begin
            col_idx <= col_idx + 1'b1;
            state   <= SETTLE;
          end
        end
        EVAL: begin
          col_o <= '1;
          match <= match_nxt;
          prev  <= snap;
          deb   <= deb_nxt;
          pend  <= mask_nxt;
          if (enc_any) begin
            state       <= EMIT;
            key_valid_o <= 1'b1;
            key_code_o  <= enc_idx;
`ifdef KPYD_SCAN_RELEASE_EN
            key_release_o <= ~deb_nxt[enc_idx];
`endif
          end else begin
            state <= SETTLE;
          end
        end
        EMIT: begin
          col_o <= '1;
          if (xfer) begin
            pend        <= mask_nxt;
            key_valid_o <= enc_any;
            key_code_o  <= enc_idx;
`ifdef KPYD_SCAN_RELEASE_EN
            key_release_o <= ~deb_nxt[enc_idx];
`endif
            if (!enc_any) begin
              col_idx <= '0;
              state   <= SETTLE;
            end
          end
        end
      endcase
    end
  end

`ifndef KPYD_SCAN_RELEASE_EN
  assign key_release_o = 1'b0;
`endif

endmodule

// File: tb/tb_kpyd_scanner.sv
// Self-checking bench for kpyd_scanner (4x4, settle 4, 3 stable scans).
// Directed tables, multi-cycle corner cases and a random event scoreboard.
module tb_kpyd_scanner;

  localparam int cols   = 4;
  localparam int rows   = 4;
  localparam int period = 21;

`ifdef KPYD_SCAN_RELEASE_EN
  localparam bit rel_en = 1'b1;
`else
  localparam bit rel_en = 1'b0;
`endif

  typedef struct {
    int   code;
    bit   rel;
    longint at;
  } ev_t;

  typedef struct {
    int         cycles;
    logic [3:0] col;
  } col_vec_t;

  typedef struct {
    logic [15:0] keys;
    int          n_ev;
    int          code0;
    bit          rel0;
  } key_vec_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic [3:0]  col_o;
  logic [3:0]  row_i;
  logic        key_valid_o;
  logic        key_ready_i = 1'b0;
  logic [3:0]  key_code_o;
  logic        key_release_o;

  logic [15:0] keys = '0;
  int          n_cmp = 0;
  int          n_bad = 0;
  longint      cyc = 0;
  ev_t         got[$];
  ev_t         expq[$];
  bit          rand_rdy = 1'b0;
  bit          seen_valid = 1'b0;

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        prel = 1'b0;
  logic [3:0]  pcode = '0;

  kpyd_scanner #(
    .cols_p(cols),
    .rows_p(rows),
    .settle_cycles_p(4),
    .stable_scans_p(3)
  ) dut (
    .clk_i        (clk),
    .reset_i      (reset_i),
    .col_o        (col_o),
    .row_i        (row_i),
    .key_valid_o  (key_valid_o),
    .key_ready_i  (key_ready_i),
    .key_code_o   (key_code_o),
    .key_release_o(key_release_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // keypad: a row reads low when a pressed key sits on a low column
  always_comb begin
    row_i = '1;
    for (int c = 0; c < cols; c++) begin
      for (int r = 0; r < rows; r++) begin
        if (!col_o[c] && keys[c*rows+r]) row_i[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // handshake monitor: stability under backpressure, transfer log
  always @(negedge clk) begin
    if (key_valid_o) seen_valid = 1'b1;
    if (reset_i && pv && !pr) begin
      check("hold_stable",
            {key_valid_o, key_code_o, key_release_o},
            {1'b1, pcode, prel});
    end
    if (reset_i && key_valid_o && key_ready_i) begin
      got.push_back('{int'(key_code_o), key_release_o, cyc});
    end
    pv    = key_valid_o;
    pr    = key_ready_i;
    pcode = key_code_o;
    prel  = key_release_o;
  end

  // random consumer readiness
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) key_ready_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic at_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int maxc, input string name);
    int k;
    k = 0;
    while (!key_valid_o && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(name, key_valid_o, 1);
  endtask

  task automatic do_reset();
    at_edge();
    reset_i = 1'b0;
    ticks(3);
    reset_i = 1'b1;
  endtask

  // expected events for a steady change of the held key map
  function automatic void model(input logic [15:0] o,
                                input logic [15:0] n);
    for (int i = 0; i < 16; i++) begin
      if (n[i] && !o[i]) begin
        expq.push_back('{i, 1'b0, 0});
      end else if (rel_en && o[i] && !n[i]) begin
        expq.push_back('{i, 1'b1, 0});
      end
    end
  endfunction

  col_vec_t cvec[5];
  key_vec_t kvec[6];

  initial begin
    logic [15:0] old_keys;
    logic [15:0] nk;
    int k;
    int nmin;

    cvec[0] = '{5, 4'b1110};
    cvec[1] = '{5, 4'b1101};
    cvec[2] = '{5, 4'b1011};
    cvec[3] = '{5, 4'b0111};
    cvec[4] = '{1, 4'b1111};

    kvec[0] = '{16'h0040, 1, 6, 1'b0};
    kvec[1] = '{16'h0000, rel_en ? 1 : 0, 6, 1'b1};
    kvec[2] = '{16'h1008, 2, 3, 1'b0};
    kvec[3] = '{16'h1000, rel_en ? 1 : 0, 3, 1'b1};
    kvec[4] = '{16'h0000, rel_en ? 1 : 0, 12, 1'b1};
    kvec[5] = '{16'h8001, 2, 0, 1'b0};

    // reset state
    ticks(2);
    check("rst_col", col_o, 4'hf);
    check("rst_valid", key_valid_o, 0);
    check("rst_code", key_code_o, 0);
    check("rst_rel", key_release_o, 0);
    reset_i = 1'b1;

    // column strobe sequence, two scans
    for (int s = 0; s < 2; s++) begin
      foreach (cvec[i]) begin
        for (int c = 0; c < cvec[i].cycles; c++) begin
          @(negedge clk);
          check("col_step", col_o, cvec[i].col);
        end
      end
    end

    // table of steady key maps
    at_edge();
    key_ready_i = 1'b1;
    foreach (kvec[i]) begin
      at_edge();
      keys = kvec[i].keys;
      got.delete();
      ticks(6 * period);
      check("ev_count", got.size(), kvec[i].n_ev);
      if (got.size() > 0) begin
        check("ev_code", got[0].code, kvec[i].code0);
        check("ev_rel", got[0].rel, kvec[i].rel0);
      end
    end

    // backpressure with two simultaneous presses
    do_reset();
    at_edge();
    key_ready_i = 1'b0;
    keys = 16'h0202;
    wait_valid(4 * period + 2, "bp_valid");
    ticks(50);
    check("bp_hold_valid", key_valid_o, 1);
    check("bp_hold_code", key_code_o, 1);
    check("bp_hold_col", col_o, 4'hf);
    at_edge();
    got.delete();
    key_ready_i = 1'b1;
    ticks(3);
    check("bp_count", got.size(), 2);
    if (got.size() == 2) begin
      check("bp_first", got[0].code, 1);
      check("bp_second", got[1].code, 9);
      check("bp_gap", got[1].at - got[0].at, 1);
    end
    k = 0;
    while (col_o != 4'b1110 && k < 5) begin
      @(negedge clk);
      k++;
    end
    check("bp_resume", col_o, 4'b1110);

    // bounce: key present on alternate scans only
    do_reset();
    at_edge();
    keys = '0;
    key_ready_i = 1'b1;
    got.delete();
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      ticks(period - 1);
      at_edge();
    end
    keys = '0;
    ticks(4 * period);
    check("bounce_valid", seen_valid, 0);
    check("bounce_count", got.size(), 0);

    // reset while an event is pending
    do_reset();
    at_edge();
    key_ready_i = 1'b0;
    keys = 16'h0040;
    wait_valid(4 * period + 2, "mid_valid");
    at_edge();
    reset_i = 1'b0;
    #1;
    check("mid_rst_valid", key_valid_o, 0);
    check("mid_rst_col", col_o, 4'hf);
    ticks(2);
    reset_i = 1'b1;
    at_edge();
    got.delete();
    key_ready_i = 1'b1;
    ticks(5 * period);
    check("repress_count", got.size(), 1);
    if (got.size() == 1) begin
      check("repress_code", got[0].code, 6);
      check("repress_rel", got[0].rel, 0);
    end

    // random key maps against the event model
    do_reset();
    at_edge();
    keys = '0;
    got.delete();
    expq.delete();
    old_keys = '0;
    rand_rdy = 1'b1;
    for (int it = 0; it < 14; it++) begin
      nk = (it == 13) ? 16'h0000 : 16'($urandom & $urandom);
      model(old_keys, nk);
      old_keys = nk;
      at_edge();
      keys = nk;
      ticks(260);
    end
    rand_rdy = 1'b0;
    at_edge();
    key_ready_i = 1'b1;
    ticks(200);
    check("rand_count", got.size(), expq.size());
    nmin = (got.size() < expq.size()) ? got.size() : expq.size();
    for (int i = 0; i < nmin; i++) begin
      check("rand_code", got[i].code, expq[i].code);
      check("rand_rel", got[i].rel, expq[i].rel);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/kpyd_scanner.md
# kpyd_scanner

Matrix keypad scanner that drives the keypad column strobes, samples the row lines, and emits debounced key events. It is the source side of the keypad path: it produces the per-key press information that downstream logic consumes, using whole-matrix scan snapshots instead of a per-signal counter. Events leave on a valid/ready handshake toward the key consumer.

## Interface
- cols_p, 4: number of column strobes (≥2).
- rows_p, 4: number of row inputs (≥1).
- settle_cycles_p, 16: cycles a column is held low before its rows are sampled (≥1).
- stable_scans_p, 4: consecutive identical scans required before the debounced map is committed (≥1).
- code_w_lp (localparam): $clog2(rows_p*cols_p).

Ports:
- clk_i  in  1  clock; all logic on posedge.
- reset_i  in  1  asynchronous, active-low reset.
- col_o  out  cols_p  column strobes, active-low, at most one bit low.
- row_i  in  rows_p  row lines, active-low (pulled up externally); already synchronised upstream.
- key_valid_o  out  1  event available.
- key_ready_i  in  1  consumer accepts the event.
- key_code_o  out  code_w_lp  key index = col*rows_p + row.
- key_release_o  out  1  1 = release event, 0 = press event.

## Operation
- Reset values: col_o all ones, key_valid_o 0, key_code_o 0, key_release_o 0. Snapshot, previous snapshot, debounced map, match counter, and column index all 0.
- FSM states: SETTLE, SAMPLE, EVAL, EMIT.
- SETTLE: col_o[col_idx] low, all others high. Settle counter runs settle_cycles_p cycles, then go to SAMPLE.
- SAMPLE, 1 cycle: snapshot[col_idx*rows_p +: rows_p] = ~row_i. If col_idx == cols_p-1, go to EVAL with col_idx = 0. Otherwise increment col_idx and go to SETTLE.
- EVAL, 1 cycle, col_o all ones:
  - If snapshot == previous snapshot, the match counter increments, saturating at stable_scans_p-1. Otherwise it clears to 0.
  - previous snapshot = snapshot.
  - Commit when the match counter, after this update, equals stable_scans_p-1 and snapshot != debounced map. On commit, the diff mask = snapshot ^ debounced map and the debounced map = snapshot.
  - Go to EMIT if the diff mask has reportable bits. Otherwise go to SETTLE.
  - With stable_scans_p=1, every scan commits.
- EMIT: col_o all ones and scanning paused.
  - Present the lowest-index reportable diff bit: key_code_o is its index, key_release_o = ~debounced bit.
  - On valid&&ready, clear that bit. The next reportable bit is presented the next cycle with no bubble.
  - When no reportable bits remain, valid drops and the FSM goes to SETTLE, column 0.
- Reportable bits: press bits always. Release bits only per Configuration.
- Simultaneous changes in one commit are reported lowest index first.
- Asynchronous reset at any time returns every register to its reset value immediately. Pending events are dropped.

## Timing
- Scan period: cols_p*(settle_cycles_p+1)+1 cycles (EVAL included), plus EMIT cycles.
- First column goes low on the first posedge after reset_i rises.
- key_valid_o rises the cycle after the committing EVAL.
- Steady press latency from the first scan that sees the key: stable_scans_p scan periods, +1 cycle.
- Handshake rules:
  - key_code_o and key_release_o are stable while key_valid_o=1 and key_ready_i=0.
  - valid never drops without a transfer, except on reset.
  - ready may be high before valid; this does not cause a transfer.

## Configuration
- KPYD_SCAN_RELEASE_EN defined: release bits in the diff mask are reportable and are emitted with key_release_o=1.
- KPYD_SCAN_RELEASE_EN undefined:
  - Releases update the debounced map silently and produce no event.
  - key_release_o is tied 0.
  - A commit containing only releases goes straight back to SETTLE.

## Structure
- kpyd_pkg holds:
  - state enum kpyd_scan_state_e (SETTLE, SAMPLE, EVAL, EMIT);
  - key code width function kpyd_code_w(rows, cols).
- Sub-module kpyd_prio_enc: parameterised lowest-set-bit priority encoder with outputs index and any. It is instantiated on the reportable diff mask.

## Test plan
All scenarios use cols_p=4, rows_p=4, settle_cycles_p=4, stable_scans_p=3, giving a 21-cycle scan period.
- Reset:
  - During reset, col_o=4'b1111 and key_valid_o=0.
  - After release, col_o steps 1110→1101→1011→0111, each for 5 cycles, followed by 1 cycle of 1111.
- Single press: row_i[2] low whenever col_o[1] is low, held → key_valid_o=1, key_code_o=6, key_release_o=0 within 4 scan periods; one event only.
- Bounce: press pattern present on alternate scans for 10 scans → key_valid_o stays 0.
- Backpressure: keys 1 and 9 steady, key_ready_i=0 for 50 cycles → valid held with code 1 and col_o=1111. Raising ready → code 1 then code 9 on consecutive cycles, then scanning resumes.
- Release: key 6 pressed then released:
  - with KPYD_SCAN_RELEASE_EN → event code 6, key_release_o=1;
  - without the macro → no event.
- Reset mid-EMIT: assert reset_i low while valid=1 → valid drops immediately. Re-press after reset is reported again as code 6 press.
